// File: rtl/scmp_op_dispatch_pkg.sv
// Microcode entry labels and dispatch-queue entry type for the SC/MP sequencer.
// SCMP_ILLEGAL_TRAP_EN adds UCLBL_ILL as the decode target for unmatched opcodes.
package scmp_microcode_pak;

    localparam int unsigned OP_W = 8;

    typedef enum logic [3:0] {
        UCLBL_FETCH = 4'd0,
        UCLBL_DLY   = 4'd1,
        UCLBL_XAE   = 4'd2,
        UCLBL_ST    = 4'd3,
        UCLBL_DAD   = 4'd4,
        UCLBL_LD    = 4'd5,
        UCLBL_DAE   = 4'd6,
        UCLBL_LDE   = 4'd7,
        UCLBL_ILD   = 4'd8,
        UCLBL_DLD   = 4'd9,
        UCLBL_JMP   = 4'd10,
        UCLBL_XPAL  = 4'd11,
        UCLBL_XPAH  = 4'd12,
        UCLBL_CL    = 4'd13
`ifdef SCMP_ILLEGAL_TRAP_EN
        , UCLBL_ILL = 4'd14
`endif
    } NEXTPC_t;

    // Label given to opcodes that match no decode rule
`ifdef SCMP_ILLEGAL_TRAP_EN
    localparam NEXTPC_t UCLBL_UNMATCHED = UCLBL_ILL;
`else
    localparam NEXTPC_t UCLBL_UNMATCHED = UCLBL_FETCH;
`endif

    typedef struct packed {
        logic [OP_W-1:0] op;
        NEXTPC_t         pc;
        logic            two_byte;
    } disp_entry_t;

endpackage

// File: rtl/scmp_op_dispatch_decode.sv
// Combinational opcode decoder: first matching rule wins.
// SCMP_ILLEGAL_TRAP_EN selects the label for unmatched opcodes (via the package).
module scmp_op_decode
    import scmp_microcode_pak::*;
(
    input  logic [OP_W-1:0] i_op,
    output NEXTPC_t         o_pc_c,
    output logic            o_two_byte_c
);

    always_comb begin
        o_pc_c       = UCLBL_UNMATCHED;
        o_two_byte_c = i_op[7];
        if (i_op == 8'h8F)
            o_pc_c = UCLBL_DLY;
        else if (i_op == 8'h01)
            o_pc_c = UCLBL_XAE;
        else if (i_op[7:3] == 5'b11001 && i_op[2:0] != 3'b100)
            o_pc_c = UCLBL_ST;
        else if (i_op[7:3] == 5'b11101)
            o_pc_c = UCLBL_DAD;
        else if (i_op[7:6] == 2'b11)
            o_pc_c = UCLBL_LD;
        else if (i_op == 8'h68)
            o_pc_c = UCLBL_DAE;
        else if (i_op[7:6] == 2'b01 && i_op[2:0] == 3'b000)
            o_pc_c = UCLBL_LDE;
        else if (i_op[7:2] == 6'b101010)
            o_pc_c = UCLBL_ILD;
        else if (i_op[7:2] == 6'b101110)
            o_pc_c = UCLBL_DLD;
        else if (i_op[7:4] == 4'b1001)
            o_pc_c = UCLBL_JMP;
        else if (i_op[7:2] == 6'b001100)
            o_pc_c = UCLBL_XPAL;
        else if (i_op[7:2] == 6'b001101)
            o_pc_c = UCLBL_XPAH;
        else if (i_op[7:1] == 7'b0000001)
            o_pc_c = UCLBL_CL;
    end

endmodule

// File: rtl/scmp_op_dispatch.sv
// Decoded-opcode dispatch FIFO between SC/MP fetch and the microcode sequencer.
// Decode target for unmatched opcodes depends on SCMP_ILLEGAL_TRAP_EN (see package).
module scmp_op_dispatch
    import scmp_microcode_pak::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [OP_W-1:0]  op_in,
    input  logic             op_valid,
    output logic             op_ready,
    output logic             disp_valid,
    input  logic             disp_ready,
    output logic [OP_W-1:0]  disp_op,
    output NEXTPC_t          disp_pc,
    output logic             disp_two_byte,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    disp_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    NEXTPC_t           w_dec_pc;
    logic              w_dec_two_byte;
    logic              w_push;
    logic              w_pop;
    disp_entry_t       w_head;

    scmp_op_decode u_decode (
        .i_op         (op_in),
        .o_pc_c       (w_dec_pc),
        .o_two_byte_c (w_dec_two_byte)
    );

    // Handshake flags derive from registered occupancy only
    assign op_ready   = rst_n && (r_count < CNT_W'(DEPTH));
    assign disp_valid = (r_count != '0);
    assign w_push     = op_valid && op_ready && !flush;
    assign w_pop      = disp_valid && disp_ready && !flush;
    assign count      = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{op: op_in, pc: w_dec_pc, two_byte: w_dec_two_byte};
        end
    end

    // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Mask stale storage so an empty queue presents reset values
    always_comb begin
        w_head = '{op: '0, pc: UCLBL_FETCH, two_byte: 1'b0};
        if (disp_valid) begin
            w_head = r_mem[r_rd_ptr];
        end
    end

    assign disp_op       = w_head.op;
    assign disp_pc       = w_head.pc;
    assign disp_two_byte = w_head.two_byte;

endmodule
